// File: rtl/phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// phase_sequencer_if
//
// Purpose:
//   Bundles the control inputs and phase outputs of the phase sequencer so
//   that a game controller (master) and the sequencer (slave) can be wired
//   through a single port.
//
// Signals:
//   tick          master -> slave  timebase enable, one clk wide
//   start         master -> slave  level; starts a game from IDLE or DONE
//   abort         master -> slave  synchronous return to IDLE
//   answerIn      master -> slave  player-answer pulse (used only in ANSWER)
//   prelimPeriod  slave -> master  high while in PRELIM
//   answerPeriod  slave -> master  high while in ANSWER
//   postPeriod    slave -> master  high while in POST
//   levelChng     slave -> master  high while in PRELIM with level != 0
//   level[2:0]    slave -> master  current 0-based level index
//   timedOut      slave -> master  ANSWER ended by timeout (visible in POST/DONE)
//   done          slave -> master  high while in DONE
// ---------------------------------------------------------------------------
interface phase_sequencer_if;
    logic       tick;
    logic       start;
    logic       abort;
    logic       answerIn;

    logic       prelimPeriod;
    logic       answerPeriod;
    logic       postPeriod;
    logic       levelChng;
    logic [2:0] level;
    logic       timedOut;
    logic       done;

    modport master (
        output tick,
        output start,
        output abort,
        output answerIn,
        input  prelimPeriod,
        input  answerPeriod,
        input  postPeriod,
        input  levelChng,
        input  level,
        input  timedOut,
        input  done
    );

    modport slave (
        input  tick,
        input  start,
        input  abort,
        input  answerIn,
        output prelimPeriod,
        output answerPeriod,
        output postPeriod,
        output levelChng,
        output level,
        output timedOut,
        output done
    );
endinterface

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//
// Purpose:
//   Sequences a multi-level quiz game through the phases
//   IDLE -> PRELIM -> ANSWER -> POST -> (PRELIM of next level | DONE).
//   PRELIM and POST last a fixed number of timebase ticks; ANSWER lasts at
//   most ANSWER_TICKS ticks and ends early on a player answer. Every phase
//   output is decoded straight from registers, so no input ever reaches an
//   output combinationally.
//
// Parameters:
//   PRELIM_TICKS  ticks spent in PRELIM            (1..65535)
//   ANSWER_TICKS  maximum ticks spent in ANSWER    (1..65535)
//   POST_TICKS    ticks spent in POST              (1..65535)
//   NUM_LEVELS    levels per game                  (1..8)
//
// Ports:
//   clk     sole clock, rising-edge
//   resetN  asynchronous active-low reset
//   bus     phase_sequencer_if.slave (controls in, phase outputs out)
// ---------------------------------------------------------------------------
module phase_sequencer #(
    parameter logic [15:0] PRELIM_TICKS = 16'd500,
    parameter logic [15:0] ANSWER_TICKS = 16'd3000,
    parameter logic [15:0] POST_TICKS   = 16'd1000,
    parameter int          NUM_LEVELS   = 8
) (
    input  logic               clk,
    input  logic               resetN,
    phase_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRELIM = 3'd1,
        S_ANSWER = 3'd2,
        S_POST   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] PRELIM_LOAD = PRELIM_TICKS - 16'd1;
    localparam logic [15:0] ANSWER_LOAD = ANSWER_TICKS - 16'd1;
    localparam logic [15:0] POST_LOAD   = POST_TICKS - 16'd1;
    localparam logic [2:0]  LAST_LEVEL  = 3'(NUM_LEVELS - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  level_q;
    logic [2:0]  level_d;
    logic        timed_out_q;
    logic        timed_out_d;

    // A timed phase finishes on the edge of a ticking cycle with cnt at 0.
    logic        expire;
    assign expire = bus.tick && (cnt_q == 16'd0);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            level_q     <= 3'd0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            timed_out_q <= timed_out_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        timed_out_d = timed_out_q;

        if (bus.abort) begin
            // Abort outranks everything else, including a simultaneous start.
            state_d     = S_IDLE;
            cnt_d       = 16'd0;
            level_d     = 3'd0;
            timed_out_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A new game always begins at level 0 with a clean flag.
                    if (bus.start) begin
                        state_d     = S_PRELIM;
                        cnt_d       = PRELIM_LOAD;
                        level_d     = 3'd0;
                        timed_out_d = 1'b0;
                    end
                end

                S_PRELIM: begin
                    if (expire) begin
                        state_d = S_ANSWER;
                        cnt_d   = ANSWER_LOAD;
                    end else if (bus.tick) begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end

                S_ANSWER: begin
                    // A player answer wins over a coincident timeout.
                    if (bus.answerIn) begin
                        state_d     = S_POST;
                        cnt_d       = POST_LOAD;
                        timed_out_d = 1'b0;
                    end else if (expire) begin
                        state_d     = S_POST;
                        cnt_d       = POST_LOAD;
                        timed_out_d = 1'b1;
                    end else if (bus.tick) begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end

                S_POST: begin
                    if (expire) begin
                        if (level_q == LAST_LEVEL) begin
                            // DONE keeps level and timedOut for the controller.
                            state_d = S_DONE;
                            cnt_d   = 16'd0;
                        end else begin
                            // POST separates consecutive PRELIMs, so
                            // prelimPeriod/levelChng rise afresh each level.
                            state_d     = S_PRELIM;
                            cnt_d       = PRELIM_LOAD;
                            level_d     = level_q + 3'd1;
                            timed_out_d = 1'b0;
                        end
                    end else if (bus.tick) begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end

                default: begin
                    state_d     = S_IDLE;
                    cnt_d       = 16'd0;
                    level_d     = 3'd0;
                    timed_out_d = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded only from registered state
    // -----------------------------------------------------------------------
    assign bus.prelimPeriod = (state_q == S_PRELIM);
    assign bus.answerPeriod = (state_q == S_ANSWER);
    assign bus.postPeriod   = (state_q == S_POST);
    assign bus.done         = (state_q == S_DONE);
    assign bus.levelChng    = (state_q == S_PRELIM) && (level_q != 3'd0);
    assign bus.level        = level_q;
    assign bus.timedOut     = timed_out_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
//
// Directed bench for phase_sequencer with PRELIM=2, ANSWER=3, POST=1 and
// two levels. A tick-counting reference model runs alongside the DUT and is
// compared against every output on each falling clock edge; the directed
// sequence adds hand-computed literal expectations for phase lengths,
// level/flag values, abort and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

    localparam int P_T  = 2;
    localparam int A_T  = 3;
    localparam int PO_T = 1;
    localparam int NL   = 2;

    localparam int M_IDLE = 0, M_PRELIM = 1, M_ANSWER = 2, M_POST = 3, M_DONE = 4;
    localparam int SEL_PRELIM = 0, SEL_ANSWER = 1, SEL_POST = 2;

    logic clk = 1'b0;
    logic resetN;

    int checks = 0;
    int errors = 0;

    phase_sequencer_if bus();

    phase_sequencer #(
        .PRELIM_TICKS (16'(P_T)),
        .ANSWER_TICKS (16'(A_T)),
        .POST_TICKS   (16'(PO_T)),
        .NUM_LEVELS   (NL)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase id, ticks seen in the current phase, level, flag
    int m_ph   = M_IDLE;
    int m_seen = 0;
    int m_lvl  = 0;
    int m_to   = 0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_ph = M_IDLE; m_seen = 0; m_lvl = 0; m_to = 0;
        end else if (bus.abort) begin
            m_ph = M_IDLE; m_seen = 0; m_lvl = 0; m_to = 0;
        end else begin
            case (m_ph)
                M_IDLE, M_DONE: if (bus.start) begin
                    m_ph = M_PRELIM; m_seen = 0; m_lvl = 0; m_to = 0;
                end
                M_PRELIM: if (bus.tick) begin
                    m_seen++;
                    if (m_seen == P_T) begin m_ph = M_ANSWER; m_seen = 0; end
                end
                M_ANSWER: begin
                    if (bus.answerIn) begin
                        m_ph = M_POST; m_seen = 0; m_to = 0;
                    end else if (bus.tick) begin
                        m_seen++;
                        if (m_seen == A_T) begin m_ph = M_POST; m_seen = 0; m_to = 1; end
                    end
                end
                M_POST: if (bus.tick) begin
                    m_seen++;
                    if (m_seen == PO_T) begin
                        m_seen = 0;
                        if (m_lvl == NL - 1) m_ph = M_DONE;
                        else begin m_ph = M_PRELIM; m_lvl++; m_to = 0; end
                    end
                end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model
    always @(negedge clk) begin
        check("m_prelim", int'(bus.prelimPeriod), int'(m_ph == M_PRELIM));
        check("m_answer", int'(bus.answerPeriod), int'(m_ph == M_ANSWER));
        check("m_post",   int'(bus.postPeriod),   int'(m_ph == M_POST));
        check("m_done",   int'(bus.done),         int'(m_ph == M_DONE));
        check("m_lvlchg", int'(bus.levelChng),    int'(m_ph == M_PRELIM && m_lvl != 0));
        check("m_level",  int'(bus.level),        m_lvl);
        check("m_to",     int'(bus.timedOut),     m_to);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_PRELIM: return bus.prelimPeriod;
            SEL_ANSWER: return bus.answerPeriod;
            default:    return bus.postPeriod;
        endcase
    endfunction

    // Number of consecutive cycles the selected phase output stays high
    task automatic run_len(input int sel, output int n);
        n = 0;
        while (sig(sel) && n < 200) begin
            n++;
            cyc();
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_prelim"}, int'(bus.prelimPeriod), 0);
        check({tag, "_answer"}, int'(bus.answerPeriod), 0);
        check({tag, "_post"},   int'(bus.postPeriod),   0);
        check({tag, "_done"},   int'(bus.done),         0);
        check({tag, "_lvlchg"}, int'(bus.levelChng),    0);
        check({tag, "_level"},  int'(bus.level),        0);
        check({tag, "_to"},     int'(bus.timedOut),     0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a_n;
        resetN       = 1'b0;
        bus.tick     = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.answerIn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_low("reset");
        @(negedge clk);
        resetN = 1'b1;
        cyc();

        // Full game, every ANSWER times out
        bus.tick  = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("g1_prelim_entry", int'(bus.prelimPeriod), 1);
        run_len(SEL_PRELIM, n); check("g1_prelim_len", n, 2);
        run_len(SEL_ANSWER, n); check("g1_answer_len", n, 3);
        check("g1_post_to", int'(bus.timedOut), 1);
        run_len(SEL_POST, n);   check("g1_post_len", n, 1);
        check("g1_l1_level", int'(bus.level), 1);
        check("g1_l1_lvlchg", int'(bus.levelChng), 1);
        check("g1_l1_to_clr", int'(bus.timedOut), 0);
        run_len(SEL_PRELIM, n); check("g1_prelim2_len", n, 2);
        run_len(SEL_ANSWER, n); check("g1_answer2_len", n, 3);
        run_len(SEL_POST, n);   check("g1_post2_len", n, 1);
        check("g1_done", int'(bus.done), 1);
        cyc(); cyc();
        check("g1_done_hold", int'(bus.done), 1);
        check("g1_done_level", int'(bus.level), 1);
        check("g1_done_to", int'(bus.timedOut), 1);

        // Early answer in the 2nd ANSWER cycle
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("g2_restart_level", int'(bus.level), 0);
        check("g2_restart_to", int'(bus.timedOut), 0);
        run_len(SEL_PRELIM, n); check("g2_prelim_len", n, 2);
        a_n = 0;
        if (bus.answerPeriod) a_n++;
        cyc();
        if (bus.answerPeriod) a_n++;
        bus.answerIn = 1'b1;
        cyc();
        check("g2_answer_len", a_n, 2);
        check("g2_post_entry", int'(bus.postPeriod), 1);
        check("g2_post_to", int'(bus.timedOut), 0);
        // answerIn held through POST expiry has no effect
        cyc();
        check("g2_l1_prelim", int'(bus.prelimPeriod), 1);
        check("g2_l1_level", int'(bus.level), 1);
        bus.tick = 1'b0;
        repeat (3) cyc();
        check("g2_prelim_ans_ign", int'(bus.prelimPeriod), 1);
        bus.answerIn = 1'b0;
        bus.tick     = 1'b1;
        run_len(SEL_PRELIM, n); check("g2_prelim2_len", n, 2);
        cyc(); cyc();
        bus.answerIn = 1'b1;       // coincident with the final ANSWER tick
        cyc();
        check("g2_tie_post", int'(bus.postPeriod), 1);
        check("g2_tie_to", int'(bus.timedOut), 0);
        bus.tick = 1'b0;
        cyc(); cyc();
        check("g2_post_ans_ign", int'(bus.postPeriod), 1);
        check("g2_post_ans_to", int'(bus.timedOut), 0);
        bus.answerIn = 1'b0;
        bus.tick     = 1'b1;
        cyc();
        check("g2_done", int'(bus.done), 1);

        // Sparse timebase: tick on every 4th PRELIM cycle
        bus.tick  = 1'b0;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        n = 0;
        while (bus.prelimPeriod && n < 100) begin
            n++;
            bus.tick = (n % 4 == 0);
            cyc();
        end
        check("g3_sparse_prelim_len", n, 8);
        check("g3_sparse_answer", int'(bus.answerPeriod), 1);

        // Abort during ANSWER at level 1
        bus.tick = 1'b1;
        run_len(SEL_ANSWER, n); check("g4_answer_len", n, 3);
        run_len(SEL_POST, n);   check("g4_post_len", n, 1);
        run_len(SEL_PRELIM, n); check("g4_prelim_len", n, 2);
        check("g4_in_answer", int'(bus.answerPeriod), 1);
        check("g4_level1", int'(bus.level), 1);
        bus.abort = 1'b1;
        cyc();
        check_all_low("abort");
        bus.start = 1'b1;
        cyc();
        check("abort_start_idle", int'(bus.prelimPeriod), 0);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        cyc();
        check("abort_release_idle", int'(bus.prelimPeriod), 0);

        // Asynchronous reset pulse in the middle of POST
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        run_len(SEL_PRELIM, n);
        run_len(SEL_ANSWER, n);
        bus.tick = 1'b0;
        check("g5_post_held", int'(bus.postPeriod), 1);
        #2 resetN = 1'b0;
        #1 check_all_low("async_rst");
        #2 resetN = 1'b1;
        cyc();
        check("rst_idle_prelim", int'(bus.prelimPeriod), 0);
        check("rst_idle_post", int'(bus.postPeriod), 0);
        bus.tick  = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("rst_restart_prelim", int'(bus.prelimPeriod), 1);
        check("rst_restart_level", int'(bus.level), 0);
        repeat (20) cyc();
        check("g5_final_done", int'(bus.done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
